// File: rtl/instr_fetch_unit_if.sv
// Word-wide instruction memory read port between the fetch unit (master) and memory (slave).
`timescale 1ns/1ps
interface instr_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32EC instruction fetch with a one-word line buffer; assembles compressed, aligned and
// word-spanning 32-bit instructions from halfword-aligned PCs.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               i_fetch_addr,
  input  logic                      i_fetch_start,
  input  logic                      i_flush_buf,
  instr_fetch_unit_if.master        mem_if,
  output logic [31:0]               o_instr,
  output logic                      o_compressed,
  output logic                      o_instr_valid,
  output logic                      o_fault,
  output logic                      o_fetch_busy
);

  typedef enum logic [1:0] {StIdle, StReqLo, StReqHi, StDone} state_e;

  state_e      r_state;
  logic        r_half_sel;
  logic [29:0] r_mem_word;
  logic        r_mem_req;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_fault;
  logic        r_buf_valid;
  logic [29:0] r_buf_tag;
  logic [31:0] r_buf_data;
  logic [15:0] r_lo_half;

  logic        w_hit;
  logic [15:0] w_hit_half;
  logic [15:0] w_mem_half;
  logic        w_ack;

  // A compressed halfword is zero-extended; otherwise the whole (offset-0) word is the instruction.
  function automatic logic [31:0] pick_instr(input logic [15:0] half, input logic [31:0] word);
    return (half[1:0] != 2'b11) ? {16'h0000, half} : word;
  endfunction

  assign w_hit      = r_buf_valid && (i_fetch_addr[31:2] == r_buf_tag);
  assign w_hit_half = i_fetch_addr[1] ? r_buf_data[31:16] : r_buf_data[15:0];
  assign w_mem_half = r_half_sel ? mem_if.mem_rdata[31:16] : mem_if.mem_rdata[15:0];
  assign w_ack      = mem_if.mem_ack && r_mem_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_half_sel  <= 1'b0;
      r_mem_word  <= '0;
      r_mem_req   <= 1'b0;
      r_instr     <= RESET_INSTR;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_lo_half   <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_fetch_start) begin
            r_half_sel <= i_fetch_addr[1];
            if (i_fetch_addr[0]) begin
              r_fault <= 1'b1;
              r_valid <= 1'b1;
              r_state <= StDone;
            end else if (w_hit && (!i_fetch_addr[1] || r_buf_data[17:16] != 2'b11)) begin
              r_instr <= pick_instr(w_hit_half, r_buf_data);
              r_fault <= 1'b0;
              r_valid <= 1'b1;
              r_state <= StDone;
            end else if (w_hit) begin
              r_lo_half  <= r_buf_data[31:16];
              r_mem_word <= i_fetch_addr[31:2] + 30'd1;
              r_mem_req  <= 1'b1;
              r_state    <= StReqHi;
            end else begin
              r_mem_word <= i_fetch_addr[31:2];
              r_mem_req  <= 1'b1;
              r_state    <= StReqLo;
            end
          end
        end
        StReqLo: begin
          if (w_ack) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_mem_word;
            r_buf_data  <= mem_if.mem_rdata;
            if (!r_half_sel || w_mem_half[1:0] != 2'b11) begin
              r_instr   <= pick_instr(w_mem_half, mem_if.mem_rdata);
              r_fault   <= 1'b0;
              r_valid   <= 1'b1;
              r_mem_req <= 1'b0;
              r_state   <= StDone;
            end else begin
              // 32-bit instruction at offset 2: upper half of this word is its low half.
              r_lo_half  <= mem_if.mem_rdata[31:16];
              r_mem_word <= r_mem_word + 30'd1;
              r_state    <= StReqHi;
            end
          end
        end
        StReqHi: begin
          if (w_ack) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_mem_word;
            r_buf_data  <= mem_if.mem_rdata;
            r_instr     <= {mem_if.mem_rdata[15:0], r_lo_half};
            r_fault     <= 1'b0;
            r_valid     <= 1'b1;
            r_mem_req   <= 1'b0;
            r_state     <= StDone;
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
      // Flush wins over a same-cycle buffer fill.
      if (i_flush_buf) r_buf_valid <= 1'b0;
    end
  end

  assign mem_if.mem_addr = {r_mem_word, 2'b00};
  assign mem_if.mem_req  = r_mem_req;
  assign o_instr         = r_instr;
  assign o_compressed    = (r_instr[1:0] != 2'b11);
  assign o_instr_valid   = r_valid;
  assign o_fault         = r_fault;
  assign o_fetch_busy    = (r_state == StReqLo) || (r_state == StReqHi) ||
                           ((r_state == StIdle) && i_fetch_start);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: wait-state memory model plus a scoreboard of
// expected instructions checked whenever InstrValid pulses.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic        comp;
    logic        fault;
    logic        chk_instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic        fetch_start = 1'b0;
  logic        flush_buf = 1'b0;
  logic [31:0] instr;
  logic        compressed;
  logic        instr_valid;
  logic        fault;
  logic        busy;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  logic [31:0] mem [0:63];
  int          wait_n = 0;
  int          cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] last_addr = '0;

  instr_fetch_unit_if mif ();

  instr_fetch_unit #(.RESET_INSTR(32'h00000013)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_fetch_addr  (fetch_addr),
    .i_fetch_start (fetch_start),
    .i_flush_buf   (flush_buf),
    .mem_if        (mif),
    .o_instr       (instr),
    .o_compressed  (compressed),
    .o_instr_valid (instr_valid),
    .o_fault       (fault),
    .o_fetch_busy  (busy)
  );

  always #5 clk = ~clk;

  // Memory answers after wait_n cycles of a held request; word index is addr[7:2].
  assign mif.mem_ack   = mif.mem_req && (cnt == wait_n);
  assign mif.mem_rdata = mem[mif.mem_addr[7:2]];

  always @(posedge clk) begin
    if (!mif.mem_req || mif.mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
    if (mif.mem_req && mif.mem_ack) begin
      acc_cnt   <= acc_cnt + 1;
      last_addr <= mif.mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && instr_valid) begin
      chk("valid_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_instr) begin
          chk("instr", instr, e.instr);
          chk("compressed", 32'(compressed), 32'(e.comp));
        end
        chk("fault", 32'(fault), 32'(e.fault));
      end
    end
  end

  task automatic expect_out(input logic [31:0] i, input logic c, input logic f, input logic ci);
    sb.push_back('{instr: i, comp: c, fault: f, chk_instr: ci});
  endtask

  task automatic fetch(input logic [31:0] addr, input int exp_lat, input int exp_acc,
                       input logic stable_chk, input logic pulse);
    int lat;
    int acc0;
    @(negedge clk);
    acc0        = acc_cnt;
    fetch_addr  = addr;
    fetch_start = 1'b1;
    #1 chk("busy_on_start", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    fetch_start = 1'b0;
    if (exp_acc == 0) chk("no_req", 32'(mif.mem_req), 32'd0);
    lat = 1;
    while (!instr_valid && lat < 40) begin
      if (stable_chk) begin
        chk("addr_stable", mif.mem_addr, {addr[31:2], 2'b00});
        chk("busy_wait", 32'(busy), 32'd1);
      end
      if (pulse && lat == 2) begin
        fetch_start = 1'b1;
        fetch_addr  = 32'h60;
      end else begin
        fetch_start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    fetch_start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("valid_one_cycle", 32'(instr_valid), 32'd0);
    chk("accesses", 32'(acc_cnt - acc0), 32'(exp_acc));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h00A00093;
    mem[4]  = 32'h45014505;
    mem[8]  = 32'h00934505;
    mem[9]  = 32'hBEEF00A0;
    mem[16] = 32'h00100093;
    mem[18] = 32'h00200113;
    mem[20] = 32'h00500513;
    mem[63] = 32'h04135555;

    repeat (3) @(negedge clk);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_comp", 32'(compressed), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;

    // Aligned 32-bit miss
    expect_out(32'h00A00093, 1'b0, 1'b0, 1'b1);
    fetch(32'h0, 2, 1, 1'b1, 1'b0);
    chk("first_addr", last_addr, 32'h0);

    // Two compressed instructions in one word; second is a buffer hit
    expect_out(32'h00004505, 1'b1, 1'b0, 1'b1);
    fetch(32'h10, 2, 1, 1'b0, 1'b0);
    expect_out(32'h00004501, 1'b1, 1'b0, 1'b1);
    fetch(32'h12, 1, 0, 1'b0, 1'b0);

    // Word-spanning miss, then hit on the second word
    expect_out(32'h00A00093, 1'b0, 1'b0, 1'b1);
    fetch(32'h22, 3, 2, 1'b0, 1'b0);
    chk("span_last_addr", last_addr, 32'h24);
    expect_out(32'h000000A0, 1'b1, 1'b0, 1'b1);
    fetch(32'h24, 1, 0, 1'b0, 1'b0);

    // Spanning from a buffer hit needs only the upper word
    expect_out(32'h00004505, 1'b1, 1'b0, 1'b1);
    fetch(32'h20, 2, 1, 1'b0, 1'b0);
    expect_out(32'h00A00093, 1'b0, 1'b0, 1'b1);
    fetch(32'h22, 2, 1, 1'b0, 1'b0);
    chk("hit_span_addr", last_addr, 32'h24);

    // Misaligned
    expect_out(32'h0, 1'b0, 1'b1, 1'b0);
    fetch(32'h31, 1, 0, 1'b0, 1'b0);

    // Wait states with an ignored mid-wait FetchStart
    wait_n = 3;
    expect_out(32'h00500513, 1'b0, 1'b0, 1'b1);
    fetch(32'h50, 5, 1, 1'b1, 1'b1);
    wait_n = 0;
    repeat (3) @(negedge clk);

    // Flush between hits
    expect_out(32'h00100093, 1'b0, 1'b0, 1'b1);
    fetch(32'h40, 2, 1, 1'b0, 1'b0);
    expect_out(32'h00100093, 1'b0, 1'b0, 1'b1);
    fetch(32'h40, 1, 0, 1'b0, 1'b0);
    flush_buf = 1'b1;
    @(negedge clk);
    flush_buf = 1'b0;
    expect_out(32'h00100093, 1'b0, 1'b0, 1'b1);
    fetch(32'h40, 2, 1, 1'b0, 1'b0);

    // Flush held across the buffer fill wins over the fill
    flush_buf = 1'b1;
    expect_out(32'h00200113, 1'b0, 1'b0, 1'b1);
    fetch(32'h48, 2, 1, 1'b0, 1'b0);
    flush_buf = 1'b0;
    expect_out(32'h00200113, 1'b0, 1'b0, 1'b1);
    fetch(32'h48, 2, 1, 1'b0, 1'b0);

    // Next-word address wraps to 0
    expect_out(32'h00930413, 1'b0, 1'b0, 1'b1);
    fetch(32'hFFFFFFFE, 3, 2, 1'b0, 1'b0);
    chk("wrap_addr", last_addr, 32'h0);
    expect_out(32'h000000A0, 1'b1, 1'b0, 1'b1);
    fetch(32'h2, 1, 0, 1'b0, 1'b0);

    // Reset during REQ_LO
    wait_n = 5;
    @(negedge clk);
    fetch_addr  = 32'h50;
    fetch_start = 1'b1;
    @(posedge clk);
    #1 fetch_start = 1'b0;
    chk("req_before_rst", 32'(mif.mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mif.mem_req), 32'd0);
    chk("rst_mid_instr", instr, 32'h00000013);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_n = 0;
    repeat (8) @(negedge clk);
    expect_out(32'h00A00093, 1'b0, 1'b0, 1'b1);
    fetch(32'h0, 2, 1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
